// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// State encodings, the legal WIDTH range and the bit-counter sizing rule.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Counter must index bits 0..WIDTH-1; a single flop still needed for WIDTH=1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell, time-shared by the serial adder controller.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full adder LSB first, one bit per clock,
// and publishes {CarryOut,SumOut} only when the whole word is complete.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a request; operands captured on StartIn
// ST_RUN  | one operand bit per clock through the full adder
// ST_DONE | result registers freshly updated; DoneOut pulses this cycle
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             StartIn,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             CarryIn,
  output logic             ReadyOut,
  output logic             BusyOut,
  output logic             DoneOut,
  output logic [WIDTH-1:0] SumOut,
  output logic             CarryOut
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_t           state_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_sum;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_next;

  serial_adder_ctrl_full_adder u_fa (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at index 0.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next = fa_s;
  end else begin : g_sum_wn
    assign sum_next = {fa_s, sh_sum[WIDTH-1:1]};
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sh_a    <= '0;
      sh_b    <= '0;
      sh_sum  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (StartIn) begin
            sh_a    <= OperandA;
            sh_b    <= OperandB;
            carry_q <= CarryIn;
            bit_cnt <= '0;
            sh_sum  <= '0;
            state_q <= ST_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          sh_sum  <= sum_next;
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          carry_q <= fa_c;
          if (bit_cnt == LAST_BIT) begin
            // Counter parks at zero instead of wrapping.
            bit_cnt <= '0;
            sum_q   <= sum_next;
            cout_q  <= fa_c;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ReadyOut = ready_q;
  assign BusyOut  = busy_q;
  assign DoneOut  = done_q;
  assign SumOut   = sum_q;
  assign CarryOut = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, checked against plain integer addition.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, c8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1, a1, b1, c1;
  logic       ready1, busy1, done1, sum1, cout1;

  int checks;
  int errors;

  logic [8:0] prev8;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .Clk(clk), .ResetN(rst_n), .StartIn(start8),
    .OperandA(a8), .OperandB(b8), .CarryIn(c8),
    .ReadyOut(ready8), .BusyOut(busy8), .DoneOut(done8),
    .SumOut(sum8), .CarryOut(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .Clk(clk), .ResetN(rst_n), .StartIn(start1),
    .OperandA(a1), .OperandB(b1), .CarryIn(c1),
    .ReadyOut(ready1), .BusyOut(busy1), .DoneOut(done1),
    .SumOut(sum1), .CarryOut(cout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] exp;
    int n;
    exp = 9'(a) + 9'(b) + 9'(ci);
    @(negedge clk);
    a8 = a; b8 = b; c8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    chk("busy_after_start", {ready8, busy8, done8}, 3'b010);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
      if (!done8) chk("result_held_in_run", {cout8, sum8}, prev8);
    end
    chk("latency8", n, 8);
    chk("result8", {cout8, sum8}, exp);
    @(negedge clk);
    chk("idle_after_done8", {ready8, busy8, done8}, 3'b100);
    chk("result8_held", {cout8, sum8}, exp);
    prev8 = exp;
  endtask

  initial begin
    int n, dones;
    logic [8:0] exp;
    logic [1:0] exp1;
    checks = 0; errors = 0; prev8 = '0;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; c8 = 0;
    start1 = 0; a1 = 0; b1 = 0; c1 = 0;
    #12;
    chk("reset_ctl8", {ready8, busy8, done8}, 3'b100);
    chk("reset_res8", {cout8, sum8}, 9'h000);
    chk("reset_ctl1", {ready1, busy1, done1, cout1, sum1}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;

    add8(8'h00, 8'h00, 1'b0);
    add8(8'hFF, 8'h01, 1'b0);
    add8(8'hA5, 8'h5A, 1'b1);
    add8(8'h3C, 8'h21, 1'b0);
    add8(8'h01, 8'h01, 1'b0);

    // StartIn held high through RUN/DONE: only one extra start, on first IDLE cycle
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    n = 0;
    while (!done8 && n < 20) begin @(negedge clk); n++; end
    chk("hold_first_latency", n, 8);
    chk("hold_first_result", {cout8, sum8}, 9'h030);
    @(negedge clk);
    chk("hold_ready_again", {ready8, done8}, 2'b10);
    @(negedge clk);
    start8 = 1'b0;
    chk("hold_second_accepted", busy8, 1'b1);
    n = 0;
    while (!done8 && n < 20) begin @(negedge clk); n++; end
    chk("hold_second_latency", n, 8);
    chk("hold_second_result", {cout8, sum8}, 9'h1FE);
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("no_extra_done", dones, 0);
    prev8 = 9'h1FE;

    // Reset in the middle of RUN discards everything
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h33; c8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctl", {ready8, busy8, done8}, 3'b100);
    chk("midreset_res", {cout8, sum8}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("midreset_no_done", dones, 0);
    prev8 = 9'h000;
    add8(8'h07, 8'h09, 1'b0);

    for (int i = 0; i < 8; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom));

    // WIDTH=1 exhaustive
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a1 = k[0]; b1 = k[1]; c1 = k[2]; start1 = 1'b1;
      exp1 = 2'(k[0]) + 2'(k[1]) + 2'(k[2]);
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin @(negedge clk); n++; end
      chk("latency1", n, 1);
      chk("result1", {cout1, sum1}, exp1);
      @(negedge clk);
      chk("idle_after_done1", {ready1, busy1, done1}, 3'b100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
